// File: rtl/shared_counters_pkg.sv
// Shared-counter pool command encodings plus the read client's error and state types.
package shared_counters_pkg;

  localparam logic [2:0] CMD_IDLE    = 3'b000;
  localparam logic [2:0] CMD_INC     = 3'b001;
  localparam logic [2:0] CMD_NEW     = 3'b010;
  localparam logic [2:0] CMD_DEALLOC = 3'b011;
  localparam logic [2:0] CMD_LOAD    = 3'b100;
  localparam logic [2:0] CMD_READ    = 3'b101;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_OVERFLOW = 2'b10,
    ERR_BADID    = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COLLECT,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sc_read_deser.sv
// Assembly register for the serial read stream.
// Each accepted segment lands at the next G-bit slot, starting with the LSB slot.
module sc_read_deser #(
  parameter int MAX_SEGS = 10,
  parameter int G        = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           valid_in,
  input  logic [G-1:0]                   seg_in,
  output logic [MAX_SEGS*G-1:0]          data,
  output logic [$clog2(MAX_SEGS+1)-1:0]  count,
  output logic                           full
);

  localparam int CNT_W = $clog2(MAX_SEGS + 1);

  assign full = (count == CNT_W'(MAX_SEGS));

  // NOTE: the assembly register is reset with the rest of the state so that
  // result_data reads zero after reset, timeout or a bad id, never X.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data  <= '0;
      count <= '0;
    end else if (valid_in && !full) begin
      for (int k = 0; k < MAX_SEGS; k++) begin
        if (count == CNT_W'(k)) data[k*G +: G] <= seg_in;
      end
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shared_counters_read_client.sv
// Read client for the shared-counter pool: issues READ, assembles the serial
// segment stream, and returns the value with a segment count and error code.
module shared_counters_read_client
  import shared_counters_pkg::*;
#(
  parameter int N        = 10,
  parameter int G        = 4,
  parameter int MAX_SEGS = N,
  parameter int TIMEOUT  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_req,
  input  logic [$clog2(N)-1:0]           rd_id,
  output logic                           rd_ready,
  output logic [2:0]                     command_in,
  output logic [$clog2(N)-1:0]           id,
  input  logic [G-1:0]                   rdata_in,
  input  logic                           rdata_valid,
  input  logic                           rdata_last,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [MAX_SEGS*G-1:0]          result_data,
  output logic [$clog2(MAX_SEGS+1)-1:0]  result_segs,
  output logic [1:0]                     result_err
);

  localparam int ID_W  = $clog2(N);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ID_W-1:0] ID_MAX = ID_W'(N - 1);

  state_e            state;
  err_e              err_q;
  logic [TMR_W-1:0]  timer;
  logic              accept;
  logic              seg_valid;
  logic              full;

  assign rd_ready   = (state == ST_IDLE);
  assign accept     = rd_req && rd_ready;
  // Beats are only stored while a read is collecting; DRAIN, IDLE and DONE drop them.
  assign seg_valid  = rdata_valid && (state == ST_WAIT || state == ST_COLLECT);
  assign result_err = err_q;

  sc_read_deser #(
    .MAX_SEGS (MAX_SEGS),
    .G        (G)
  ) u_deser (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .valid_in (seg_valid),
    .seg_in   (rdata_in),
    .data     (result_data),
    .count    (result_segs),
    .full     (full)
  );

  // NOTE: every register here uses <= so all of them see the pre-edge values
  // of each other regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      err_q        <= ERR_OK;
      timer        <= '0;
      command_in   <= CMD_IDLE;
      id           <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_req) begin
            timer <= '0;
            err_q <= ERR_OK;
            if (rd_id > ID_MAX) begin
              state        <= ST_DONE;
              err_q        <= ERR_BADID;
              result_valid <= 1'b1;
            end else begin
              state      <= ST_WAIT;
              command_in <= CMD_READ;
              id         <= rd_id;
            end
          end
        end

        ST_WAIT: begin
          if (rdata_valid) begin
            if (rdata_last) begin
              state        <= ST_DONE;
              result_valid <= 1'b1;
              command_in   <= CMD_IDLE;
              id           <= '0;
            end else begin
              state <= ST_COLLECT;
            end
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            state        <= ST_DONE;
            err_q        <= ERR_TIMEOUT;
            result_valid <= 1'b1;
            command_in   <= CMD_IDLE;
            id           <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        ST_COLLECT: begin
          if (rdata_valid) begin
            if (full) err_q <= ERR_OVERFLOW;
            if (rdata_last) begin
              state        <= ST_DONE;
              result_valid <= 1'b1;
              command_in   <= CMD_IDLE;
              id           <= '0;
            end else if (full) begin
              state <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (rdata_valid && rdata_last) begin
            state        <= ST_DONE;
            result_valid <= 1'b1;
            command_in   <= CMD_IDLE;
            id           <= '0;
          end
        end

        ST_DONE: begin
          if (result_ready) begin
            state        <= ST_IDLE;
            result_valid <= 1'b0;
            err_q        <= ERR_OK;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_counters_read_client.sv
// Bench for shared_counters_read_client: directed vector table, hand-written
// reset/last-only sequences, and random reads scored against a stream model.
module tb_shared_counters_read_client;
  import shared_counters_pkg::*;

  localparam int N        = 10;
  localparam int G        = 4;
  localparam int MAX_SEGS = 10;
  localparam int TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_id = '0;
  logic        rd_ready;
  logic [2:0]  command_in;
  logic [3:0]  id;
  logic [3:0]  rdata_in = '0;
  logic        rdata_valid = 1'b0;
  logic        rdata_last = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [39:0] result_data;
  logic [3:0]  result_segs;
  logic [1:0]  result_err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       v;
    logic       l;
    logic [3:0] d;
  } beat_t;

  typedef struct {
    logic [3:0]  rid;
    int          delay;
    int          n;
    int          gap;
    logic [63:0] vals;
    logic [39:0] xd;
    int          xs;
    logic [1:0]  xe;
    int          hold;
  } vec_t;

  beat_t stim_q[$];

  shared_counters_read_client #(
    .N        (N),
    .G        (G),
    .MAX_SEGS (MAX_SEGS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req       (rd_req),
    .rd_id        (rd_id),
    .rd_ready     (rd_ready),
    .command_in   (command_in),
    .id           (id),
    .rdata_in     (rdata_in),
    .rdata_valid  (rdata_valid),
    .rdata_last   (rdata_last),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .result_segs  (result_segs),
    .result_err   (result_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic v, input logic l, input logic [3:0] d);
    beat_t b;
    b.v = v;
    b.l = l;
    b.d = d;
    return b;
  endfunction

  // Reference: walk the per-cycle stream after the READ is issued. The first
  // valid beat must arrive within TIMEOUT cycles; the first MAX_SEGS valid beats
  // are packed LSB-first; any further valid beat flags overflow; valid+last ends.
  function automatic void model(output int end_i, output logic [39:0] d,
                                output int segs, output logic [1:0] err);
    int    nv;
    bit    seen;
    beat_t b;
    nv = 0; seen = 0;
    end_i = -1; d = '0; segs = 0; err = ERR_OK;
    for (int i = 0; i < stim_q.size() + TIMEOUT; i++) begin
      b = (i < stim_q.size()) ? stim_q[i] : '0;
      if (!seen && !b.v) begin
        if (i == TIMEOUT - 1) begin
          end_i = i;
          err   = ERR_TIMEOUT;
          return;
        end
        continue;
      end
      if (b.v) begin
        seen = 1;
        if (nv < MAX_SEGS) begin
          d    = d | (40'(b.d) << (4 * nv));
          nv++;
          segs = nv;
        end else begin
          err = ERR_OVERFLOW;
        end
        if (b.l) begin
          end_i = i;
          return;
        end
      end
    end
  endfunction

  task automatic drive_beat(input int i);
    beat_t b;
    b = (i < stim_q.size()) ? stim_q[i] : '0;
    rdata_valid = b.v;
    rdata_last  = b.l;
    rdata_in    = b.d;
  endtask

  task automatic run_txn(input logic [3:0] rid, input int hold, input logic [39:0] xd,
                         input int xs, input logic [1:0] xe, input string tag);
    int          end_i;
    logic [39:0] md;
    int          ms;
    logic [1:0]  me;
    check({tag, " rd_ready before"}, rd_ready, 1);
    rd_req = 1'b1;
    rd_id  = rid;
    step();
    rd_req = 1'b0;
    rd_id  = 4'($urandom);
    if (rid <= 4'(N - 1)) begin
      model(end_i, md, ms, me);
      check({tag, " cmd after accept"}, command_in, CMD_READ);
      check({tag, " id after accept"}, id, rid);
      check({tag, " valid low in flight"}, result_valid, 0);
      for (int i = 0; i <= end_i; i++) begin
        drive_beat(i);
        step();
        if (i < end_i) check({tag, " cmd held"}, command_in, CMD_READ);
      end
      rdata_valid = 1'b0;
      rdata_last  = 1'b0;
    end
    check({tag, " cmd done"}, command_in, CMD_IDLE);
    check({tag, " id done"}, id, 0);
    check({tag, " result_valid"}, result_valid, 1);
    check({tag, " rd_ready busy"}, rd_ready, 0);
    check({tag, " data"}, result_data, xd);
    check({tag, " segs"}, result_segs, xs);
    check({tag, " err"}, result_err, xe);
    for (int h = 0; h < hold; h++) begin
      rdata_valid = 1'($urandom);
      rdata_last  = 1'($urandom);
      rdata_in    = 4'($urandom);
      rd_req      = 1'($urandom);
      rd_id       = 4'($urandom);
      step();
      check({tag, " hold valid"}, result_valid, 1);
      check({tag, " hold data"}, result_data, xd);
      check({tag, " hold segs"}, result_segs, xs);
      check({tag, " hold err"}, result_err, xe);
      check({tag, " hold cmd"}, command_in, CMD_IDLE);
    end
    rdata_valid  = 1'b0;
    rdata_last   = 1'b0;
    rd_req       = 1'b0;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check({tag, " valid after handshake"}, result_valid, 0);
    check({tag, " rd_ready after handshake"}, rd_ready, 1);
    check({tag, " cmd after handshake"}, command_in, CMD_IDLE);
  endtask

  vec_t tbl[10];

  initial begin
    logic [63:0] vv;
    int          e;
    int          nb;
    logic [3:0]  rid;
    logic [39:0] md;
    int          ms;
    logic [1:0]  me;

    tbl[0] = '{rid: 4'd0,  delay: 1,  n: 2,  gap: 0, vals: 64'hA3,           xd: 40'hA3,         xs: 2,  xe: 2'b00, hold: 0};
    tbl[1] = '{rid: 4'd2,  delay: 0,  n: 3,  gap: 2, vals: 64'h7F1,          xd: 40'h7F1,        xs: 3,  xe: 2'b00, hold: 1};
    tbl[2] = '{rid: 4'd1,  delay: 0,  n: 0,  gap: 0, vals: 64'h0,            xd: 40'h0,          xs: 0,  xe: 2'b01, hold: 0};
    tbl[3] = '{rid: 4'd3,  delay: 2,  n: 12, gap: 0, vals: 64'hCBA987654321, xd: 40'hA987654321, xs: 10, xe: 2'b10, hold: 0};
    tbl[4] = '{rid: 4'd12, delay: 0,  n: 0,  gap: 0, vals: 64'h0,            xd: 40'h0,          xs: 0,  xe: 2'b11, hold: 0};
    tbl[5] = '{rid: 4'd9,  delay: 0,  n: 10, gap: 0, vals: 64'hA987654321,   xd: 40'hA987654321, xs: 10, xe: 2'b00, hold: 5};
    tbl[6] = '{rid: 4'd5,  delay: 0,  n: 1,  gap: 0, vals: 64'h5,            xd: 40'h5,          xs: 1,  xe: 2'b00, hold: 0};
    tbl[7] = '{rid: 4'd4,  delay: 15, n: 1,  gap: 0, vals: 64'h6,            xd: 40'h6,          xs: 1,  xe: 2'b00, hold: 0};
    tbl[8] = '{rid: 4'd6,  delay: 16, n: 1,  gap: 0, vals: 64'h6,            xd: 40'h0,          xs: 0,  xe: 2'b01, hold: 0};
    tbl[9] = '{rid: 4'd11, delay: 0,  n: 0,  gap: 0, vals: 64'h0,            xd: 40'h0,          xs: 0,  xe: 2'b11, hold: 2};

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    check("reset cmd", command_in, CMD_IDLE);
    check("reset id", id, 0);
    check("reset result_valid", result_valid, 0);
    check("reset rd_ready", rd_ready, 1);
    check("reset data", result_data, 0);
    check("reset segs", result_segs, 0);
    check("reset err", result_err, 0);
    rst = 1'b0;
    step();

    // Directed vector table
    for (int t = 0; t < 10; t++) begin
      stim_q.delete();
      vv = tbl[t].vals;
      repeat (tbl[t].delay) stim_q.push_back(mk(1'b0, 1'b0, 4'($urandom)));
      for (int k = 0; k < tbl[t].n; k++) begin
        stim_q.push_back(mk(1'b1, k == tbl[t].n - 1, vv[4*k +: 4]));
        if (k == 0) repeat (tbl[t].gap) stim_q.push_back(mk(1'b0, 1'b0, 4'($urandom)));
      end
      run_txn(tbl[t].rid, tbl[t].hold, tbl[t].xd, tbl[t].xs, tbl[t].xe, $sformatf("vec%0d", t));
    end

    // rdata_last without rdata_valid must not end the read
    stim_q.delete();
    stim_q.push_back(mk(1'b1, 1'b0, 4'h4));
    stim_q.push_back(mk(1'b0, 1'b1, 4'h9));
    stim_q.push_back(mk(1'b0, 1'b1, 4'hE));
    stim_q.push_back(mk(1'b1, 1'b1, 4'h5));
    run_txn(4'd8, 1, 40'h54, 2, 2'b00, "lastonly");

    // Reset while collecting aborts the read; late beats are ignored in IDLE
    rd_req = 1'b1;
    rd_id  = 4'd7;
    step();
    rd_req = 1'b0;
    rdata_valid = 1'b1; rdata_in = 4'h2; rdata_last = 1'b0;
    step();
    rdata_in = 4'h3;
    step();
    check("midreset cmd before", command_in, CMD_READ);
    rdata_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset cmd", command_in, CMD_IDLE);
    check("midreset result_valid", result_valid, 0);
    check("midreset rd_ready", rd_ready, 1);
    check("midreset data", result_data, 0);
    check("midreset segs", result_segs, 0);
    rdata_valid = 1'b1; rdata_last = 1'b1; rdata_in = 4'hB;
    repeat (2) step();
    rdata_valid = 1'b0; rdata_last = 1'b0;
    check("late beat result_valid", result_valid, 0);
    check("late beat rd_ready", rd_ready, 1);
    check("late beat segs", result_segs, 0);

    // Randomized reads against the stream model
    for (int r = 0; r < 40; r++) begin
      rid = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      stim_q.delete();
      repeat ($urandom_range(0, 17)) stim_q.push_back(mk(1'b0, 1'($urandom), 4'($urandom)));
      nb = $urandom_range(1, 13);
      for (int k = 0; k < nb; k++) begin
        stim_q.push_back(mk(1'b1, k == nb - 1, 4'($urandom)));
        if (k != nb - 1 && $urandom_range(0, 2) == 0)
          repeat ($urandom_range(1, 3)) stim_q.push_back(mk(1'b0, 1'($urandom), 4'($urandom)));
      end
      if (rid > 4'(N - 1)) begin
        md = '0; ms = 0; me = ERR_BADID;
      end else begin
        model(e, md, ms, me);
      end
      run_txn(rid, $urandom_range(0, 3), md, ms, me, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
